// File: rtl/ifetch_seq.sv
// Instruction-fetch stage: holds the PC, fetches over a req/ready handshake, resolves next-PC.
// Latency: 1 REQ cycle (plus one per imem_ready=0 cycle) then >=1 VALID cycle per instruction.
// Backpressure: imem_ready low holds REQ with a stable address; stall holds VALID with no retire.
module ifetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] Addr_Result,
  input  logic        Zero,
  input  logic [31:0] Read_data_1,
  input  logic        Branch,
  input  logic        nBranch,
  input  logic        Jmp,
  input  logic        Jal,
  input  logic        Jr,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic        instr_valid,
  output logic [31:0] PC_plus_4,
  output logic [31:0] link_addr,
  output logic        retire,
  output logic        pc_misalign
);

  typedef enum logic [1:0] {ST_RST, ST_REQ, ST_VALID} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] link_q, link_d;
  logic        retire_q, retire_d;
  logic        misalign_q, misalign_d;

  logic        fetch_done;
  logic        commit;
  logic        take_branch;
  logic [31:0] pc_plus_4;
  logic [31:0] next_pc;

  // FSM state register; reset parks the stage in RST with no request outstanding
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: RST always leaves on the first clocked edge, REQ waits for ready, VALID waits for no stall
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST:   state_d = ST_REQ;
      ST_REQ:   if (imem_ready) state_d = ST_VALID;
      ST_VALID: if (!stall) state_d = ST_REQ;
      default:  state_d = ST_RST;
    endcase
  end

  // FSM outputs: request only in REQ, valid only in VALID; ready/control are gated by state here
  always_comb begin
    imem_req    = (state_q == ST_REQ);
    instr_valid = (state_q == ST_VALID);
    fetch_done  = (state_q == ST_REQ) && imem_ready;
    commit      = (state_q == ST_VALID) && !stall;
  end

  // Next-PC resolution: jr beats taken branch beats j/jal beats sequential
  always_comb begin
    pc_plus_4   = pc_q + 32'd4;
    take_branch = (Branch && Zero) || (nBranch && !Zero);
    if (Jr) begin
      next_pc = {Read_data_1[31:2], 2'b00};
    end else if (take_branch) begin
      next_pc = Addr_Result;
    end else if (Jmp || Jal) begin
      next_pc = {pc_plus_4[31:28], instr_q[25:0], 2'b00};
    end else begin
      next_pc = pc_plus_4;
    end
  end

  // Datapath next values: capture on fetch, update PC/link and raise pulses on commit
  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    link_d     = link_q;
    retire_d   = 1'b0;
    misalign_d = 1'b0;
    if (fetch_done) begin
      instr_d = imem_rdata;
    end
    if (commit) begin
      pc_d       = next_pc;
      retire_d   = 1'b1;
      misalign_d = Jr && (Read_data_1[1:0] != 2'b00);
      if (Jal) begin
        link_d = pc_plus_4;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      link_q     <= 32'd0;
      retire_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      link_q     <= link_d;
      retire_q   <= retire_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_addr   = pc_q;
  assign Instruction = instr_q;
  assign PC_plus_4   = pc_plus_4;
  assign link_addr   = link_q;
  assign retire      = retire_q;
  assign pc_misalign = misalign_q;

endmodule

// File: tb/tb_ifetch_seq.sv
// Bench for ifetch_seq: expected fetch addresses are queued as each instruction is issued
// and popped when the DUT raises its next request; outputs are sampled on the falling edge.
// Memory latency and stall length are chosen per instruction.
module tb_ifetch_seq;

  logic        clock;
  logic        reset_n;
  logic [31:0] Addr_Result;
  logic        Zero;
  logic [31:0] Read_data_1;
  logic        Branch, nBranch, Jmp, Jal, Jr;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction;
  logic        instr_valid;
  logic [31:0] PC_plus_4;
  logic [31:0] link_addr;
  logic        retire;
  logic        pc_misalign;

  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_JR   = 5'b10000;
  localparam logic [4:0] F_BR   = 5'b01000;
  localparam logic [4:0] F_NBR  = 5'b00100;
  localparam logic [4:0] F_JMP  = 5'b00010;
  localparam logic [4:0] F_JAL  = 5'b00001;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_word = 32'd0;
  int          exp_gap   = 1;
  logic [31:0] cur_addr  = 32'd0;

  ifetch_seq #(.RESET_PC(32'h0000_0000)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .Addr_Result (Addr_Result),
    .Zero        (Zero),
    .Read_data_1 (Read_data_1),
    .Branch      (Branch),
    .nBranch     (nBranch),
    .Jmp         (Jmp),
    .Jal         (Jal),
    .Jr          (Jr),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .Instruction (Instruction),
    .instr_valid (instr_valid),
    .PC_plus_4   (PC_plus_4),
    .link_addr   (link_addr),
    .retire      (retire),
    .pc_misalign (pc_misalign)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic set_ctl(input logic [4:0] flags, input logic z, input logic [31:0] ar,
                         input logic [31:0] rd1);
    {Jr, Branch, nBranch, Jmp, Jal} = flags;
    Zero        = z;
    Addr_Result = ar;
    Read_data_1 = rd1;
  endtask

  // Wait (bounded) for a request, then compare its address with the queued expectation
  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clock);
      n++;
    end
    check_eq("req_gap", n, exp_gap);
    if (exp_q.size() == 0) begin
      check_eq("queue_underflow", 32'd1, 32'd0);
      cur_addr = imem_addr;
    end else begin
      cur_addr = exp_q.pop_front();
      check_eq("imem_addr", imem_addr, cur_addr);
    end
  endtask

  task automatic fetch_one(input logic [31:0] word, input int waits, input int stalls,
                           input logic [4:0] flags, input logic z, input logic [31:0] ar,
                           input logic [31:0] rd1, input logic exp_mis,
                           input logic [31:0] exp_link, input logic [31:0] exp_next);
    logic [31:0] exp_p4;
    wait_req();
    exp_p4 = cur_addr + 32'd4;
    for (int i = 0; i < waits; i++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      @(negedge clock);
      check_eq("wait_req", imem_req, 1'b1);
      check_eq("wait_addr", imem_addr, cur_addr);
      check_eq("wait_instr", Instruction, last_word);
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    set_ctl(5'b11111, 1'b1, $urandom, $urandom);
    @(negedge clock);
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    check_eq("instr_valid", instr_valid, 1'b1);
    check_eq("req_in_valid", imem_req, 1'b0);
    check_eq("instruction", Instruction, word);
    check_eq("pc_plus_4", PC_plus_4, exp_p4);
    check_eq("no_early_retire", retire, 1'b0);
    set_ctl(flags, z, ar, rd1);
    stall = (stalls > 0);
    for (int i = 0; i < stalls; i++) begin
      @(negedge clock);
      check_eq("stall_valid", instr_valid, 1'b1);
      check_eq("stall_retire", retire, 1'b0);
      check_eq("stall_pc", imem_addr, cur_addr);
      check_eq("stall_instr", Instruction, word);
    end
    stall = 1'b0;
    exp_q.push_back(exp_next);
    @(negedge clock);
    check_eq("retire", retire, 1'b1);
    check_eq("pc_misalign", pc_misalign, exp_mis);
    check_eq("link_addr", link_addr, exp_link);
    check_eq("valid_drop", instr_valid, 1'b0);
    set_ctl(F_NONE, 1'b0, 32'd0, 32'd0);
    last_word = word;
    exp_gap   = 0;
  endtask

  initial begin
    reset_n    = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'd0;
    stall      = 1'b0;
    set_ctl(F_NONE, 1'b0, 32'd0, 32'd0);
    repeat (3) @(negedge clock);
    imem_ready = 1'b1;
    set_ctl(5'b11111, 1'b1, 32'h40, 32'h26);
    @(negedge clock);
    check_eq("rst_req", imem_req, 1'b0);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_valid", instr_valid, 1'b0);
    check_eq("rst_instr", Instruction, 32'h0);
    check_eq("rst_link", link_addr, 32'h0);
    check_eq("rst_retire", retire, 1'b0);
    check_eq("rst_misalign", pc_misalign, 1'b0);
    imem_ready = 1'b0;
    set_ctl(F_NONE, 1'b0, 32'd0, 32'd0);
    reset_n = 1'b1;
    exp_gap = 1;
    exp_q.push_back(32'h0);

    //        word          waits stalls flags                 Z     Addr_Result   Read_data_1   mis   link        next
    fetch_one(32'hA500_0000, 0, 0, F_NONE,               1'b0, 32'h0,        32'h0,        1'b0, 32'h0,  32'h4);
    fetch_one(32'hA500_0004, 0, 0, F_NONE,               1'b0, 32'h0,        32'h0,        1'b0, 32'h0,  32'h8);
    fetch_one(32'hA500_0008, 3, 0, F_NONE,               1'b0, 32'h0,        32'h0,        1'b0, 32'h0,  32'hC);
    fetch_one(32'hA500_000C, 0, 0, F_NONE,               1'b0, 32'h0,        32'h0,        1'b0, 32'h0,  32'h10);
    fetch_one(32'h1000_0001, 0, 0, F_BR,                 1'b1, 32'h40,       32'h0,        1'b0, 32'h0,  32'h40);
    fetch_one(32'h1000_0002, 1, 0, F_BR,                 1'b0, 32'h80,       32'h0,        1'b0, 32'h0,  32'h44);
    fetch_one(32'h1400_0003, 0, 0, F_NBR,                1'b0, 32'h10,       32'h0,        1'b0, 32'h0,  32'h10);
    fetch_one(32'h1400_0004, 0, 0, F_NBR,                1'b1, 32'h40,       32'h0,        1'b0, 32'h0,  32'h14);
    fetch_one(32'h0800_0008, 0, 0, F_JMP,                1'b0, 32'h0,        32'h0,        1'b0, 32'h0,  32'h20);
    fetch_one(32'h0C00_0100, 0, 0, F_JAL,                1'b0, 32'h0,        32'h0,        1'b0, 32'h24, 32'h400);
    fetch_one(32'h0000_0008, 0, 0, F_JR,                 1'b0, 32'h0,        32'h26,       1'b1, 32'h24, 32'h24);
    fetch_one(32'h0000_0009, 2, 0, F_JR,                 1'b0, 32'h0,        32'h30,       1'b0, 32'h24, 32'h30);
    fetch_one(32'hA500_0030, 0, 5, F_NONE,               1'b0, 32'h0,        32'h0,        1'b0, 32'h24, 32'h34);
    fetch_one(32'h0800_0008, 0, 0, F_JR | F_BR | F_JMP,  1'b1, 32'h100,      32'h50,       1'b0, 32'h24, 32'h50);
    fetch_one(32'h1000_0005, 0, 0, F_BR | F_JMP,         1'b1, 32'h200,      32'h0,        1'b0, 32'h24, 32'h200);
    fetch_one(32'h0000_0008, 0, 0, F_JR,                 1'b0, 32'h0,        32'hFFFF_FFFF, 1'b1, 32'h24, 32'hFFFF_FFFC);
    fetch_one(32'hA500_0011, 0, 0, F_NONE,               1'b0, 32'h0,        32'h0,        1'b0, 32'h24, 32'h0);
    fetch_one(32'h0000_0008, 0, 0, F_JR,                 1'b0, 32'h0,        32'h50,       1'b0, 32'h24, 32'h50);

    // Abort a fetch at 0x50 with an asynchronous reset between clock edges
    wait_req();
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("arst_req", imem_req, 1'b0);
    check_eq("arst_addr", imem_addr, 32'h0);
    check_eq("arst_valid", instr_valid, 1'b0);
    check_eq("arst_instr", Instruction, 32'h0);
    check_eq("arst_link", link_addr, 32'h0);
    check_eq("arst_retire", retire, 1'b0);
    check_eq("arst_misalign", pc_misalign, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset_n   = 1'b1;
    exp_gap   = 1;
    last_word = 32'd0;
    exp_q.push_back(32'h0);
    fetch_one(32'hA500_0000, 0, 0, F_NONE, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h4);
    wait_req();
    check_eq("queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_seq.md
# ifetch_seq

Sequenced instruction-fetch stage for the Minisys 32-bit core. It sits directly upstream of the execute unit. It holds the PC, fetches each instruction from an external instruction memory over a ready/request handshake, and presents it to decode/execute. It then resolves next-PC from the execute unit's `Addr_Result`/`Zero` and the controller's jump/branch flags. It replaces the purely combinational PC update with a small FSM so instruction memory may take any number of cycles.

## Interface

Parameters:
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset. Must be word-aligned.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `Addr_Result`  in  32  branch target from execute (`PC_plus_4 + (imm<<2)`).
- `Zero`  in  1  execute result-is-zero flag.
- `Read_data_1`  in  32  rs value from decoder; the jr target.
- `Branch`  in  1  beq.
- `nBranch`  in  1  bne.
- `Jmp`  in  1  j.
- `Jal`  in  1  jal.
- `Jr`  in  1  jr.
- `stall`  in  1  hold current instruction; no retire.
- `imem_req`  out  1  fetch request, level.
- `imem_addr`  out  32  fetch address; equals PC.
- `imem_ready`  in  1  memory has `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  fetched word.
- `Instruction`  out  32  instruction presented to decode/execute.
- `instr_valid`  out  1  `Instruction` valid; downstream control is meaningful.
- `PC_plus_4`  out  32  PC+4 of the presented instruction.
- `link_addr`  out  32  registered return address written by jal.
- `retire`  out  1  one-cycle pulse when the presented instruction commits.
- `pc_misalign`  out  1  one-cycle pulse when a jr target has nonzero bits [1:0].

## Operation

FSM states: `RST`, `REQ`, `VALID`.
- `RST`: entered asynchronously while `reset_n`=0.
  - Reset values: PC=`RESET_PC`; `Instruction`=0; `link_addr`=0; `imem_req`=0; `instr_valid`=0; `retire`=0; `pc_misalign`=0.
  - Always moves to `REQ` on the first clock edge with `reset_n`=1.
- `REQ`: `imem_req`=1, `imem_addr`=PC.
  - If `imem_ready`=1: `Instruction`<=`imem_rdata`, go to `VALID`.
  - Otherwise stay in `REQ`, holding the request and address stable.
- `VALID`: `instr_valid`=1, `imem_req`=0.
  - If `stall`=1: hold everything.
  - If `stall`=0: retire. PC<=next_pc, `retire` pulses on the following cycle, go to `REQ`.
- Next-PC priority, highest first:
  1. `Jr`: `{Read_data_1[31:2],2'b00}`. If `Read_data_1[1:0]`≠0, pulse `pc_misalign`; the target is still taken with low bits cleared.
  2. (`Branch`&`Zero`) | (`nBranch`&~`Zero`): `Addr_Result`.
  3. `Jmp`|`Jal`: `{PC_plus_4[31:28], Instruction[25:0], 2'b00}`.
  4. Otherwise: `PC_plus_4`.
- `link_addr`<=`PC_plus_4` only on retire with `Jal`=1; otherwise it holds.
- `PC_plus_4` = PC+4, combinational, 32-bit wrap (PC 32'hFFFF_FFFC gives 0).
- Control inputs are ignored outside `VALID`.
- `imem_ready` is ignored outside `REQ`.
- Multiple asserted control flags resolve by the priority above; no error is flagged.

## Timing

- Minimum 2 cycles per instruction: 1 `REQ` cycle with immediate ready, plus 1 `VALID` cycle.
- Each extra cycle of `imem_ready`=0 adds one cycle.
- `Instruction`, `instr_valid` and `PC_plus_4` are stable throughout `VALID`. Execute is combinational within that cycle.
- The PC update, `link_addr` write and `retire`/`pc_misalign` pulses occur at the edge leaving `VALID`.
- `stall` is sampled every `VALID` cycle. A stall of N cycles extends `VALID` by N.
- Reset mid-fetch or mid-`VALID` aborts immediately, with all outputs at reset values. No retire is issued for the aborted instruction.
- First request: `imem_req` rises on the first edge after `reset_n` deasserts, with `imem_addr`=`RESET_PC`.

## Test plan

- Reset/sequential: `RESET_PC`=0, `imem_ready` held 1, no control flags → fetches 0,4,8,C at cycles 1,3,5,7; `retire` every 2nd cycle; `instr_valid` alternates.
- Wait states: `imem_ready` low for 3 cycles at PC=8 → `imem_req` and `imem_addr`=8 stable for 4 cycles; `Instruction` changes only on the ready cycle.
- Branch: PC=0x10, `Branch`=1, `Zero`=1, `Addr_Result`=0x40 → next fetch 0x40. Repeat with `Zero`=0 → 0x14. `nBranch` → the inverse outcomes.
- Jal/jr: PC=0x20, `Instruction[25:0]`=0x100, `Jal` → next fetch 0x400 and `link_addr`=0x24. Then `Jr`, `Read_data_1`=0x26 → next fetch 0x24 and one `pc_misalign` pulse.
- Stall: `stall`=1 for 5 cycles in `VALID` at PC=0x30 → no retire and PC stays 0x30; retire on the first cycle with `stall`=0.
- Async reset: assert `reset_n`=0 mid-`REQ` with PC=0x50, between clock edges → outputs go to reset values immediately; after release, the fetch restarts at `RESET_PC`.
